uart_rx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_rx_fifo_ctrl
// PURPOSE
//  Sequences UartReceiver: acknowledges each received/broken frame with a one-cycle receiveReq.
//  Queues data plus error flags in a FWFT FIFO for the host side.
//  Raises irq on a fill threshold, or on line silence with data pending.
//  Sits between UartReceiver and the register/bus interface.
// PARAMETERS
//  DEPTH_LOG2   4    FIFO depth = 2**DEPTH_LOG2 entries
//  ENTRY_W      12   entry = {ovf, brk, perr, data[8:0]}
// PORTS
//  clk          in   1        system clock (all logic posedge)
//  rst          in   1        synchronous reset, active-low (rst==0 resets)
//  rxData       in   9        UartReceiver dataOut
//  rxValid      in   1        UartReceiver dataReceived
//  rxParityErr  in   1        UartReceiver parityError
//  rxOverflow   in   1        UartReceiver overflow
//  rxBreak      in   1        UartReceiver break
//  rxSilence    in   1        UartReceiver silence
//  rxAck        out  1        to UartReceiver receiveReq; one-cycle pulse
//  popReq       in   1        host consumes head entry this cycle
//  headEntry    out  12       head entry; valid when !empty
//  empty        out  1        FIFO empty
//  count        out  DEPTH_LOG2+1  entries stored, 0..2**DEPTH_LOG2
//  threshold    in   DEPTH_LOG2+1  irq level; 0 disables level irq
//  flush        in   1        clears FIFO, dropped, timeoutIrq
//  dropped      out  1        sticky: frame lost, FIFO full
//  irq          out  1        (threshold!=0 && count>=threshold) | timeoutIrq
// BEHAVIOUR
//  Reset: FSM=IDLE, rxAck=0, FIFO empty (count=0, empty=1, headEntry=0), dropped=0, timeoutIrq=0, irq=0.
//  FSM IDLE: if rxValid|rxBreak -> PUSH; otherwise stay.
//  FSM PUSH (1 cycle): form entry.
//   - data = rxValid ? rxData : 0.
//   - perr = rxValid & rxParityErr; brk = rxBreak; ovf = rxOverflow.
//   - If not full, or popReq this cycle: write entry. Else set dropped, discard entry.
//   - Assert rxAck=1 this cycle -> WAIT.
//  FSM WAIT: rxAck=0. Return to IDLE once rxValid==0 && rxBreak==0.
//   - Guards against double-push while the receiver clears its flags.
//  rxAck is never high for more than one consecutive cycle.
//   - A held receiveReq would suppress dataReceived at the next stop bit.
//  Latency: rxValid rise at cycle N -> entry visible (count++) and rxAck at N+1.
//  FIFO
//   - FWFT; headEntry = mem[rdPtr], registered pointers.
//   - Pointers are DEPTH_LOG2 bits and wrap naturally.
//   - popReq when empty: ignored, no pointer move.
//   - Push+pop same cycle: count unchanged, both pointers advance.
//     Legal when full (pop frees the slot); when empty, only the push takes effect.
//  timeoutIrq
//   - Set on rising edge of rxSilence while count!=0.
//   - Cleared when count reaches 0, or on flush.
//  flush: takes priority over push and pop in the same cycle.
//   - Pushed entry is lost; dropped is NOT set.
//   - FSM continues normally; rxAck is still issued.
//  Reset mid-frame: FSM returns to IDLE.
//   - If rxValid is still high after reset, one entry is pushed and acknowledged.
//  count arithmetic: DEPTH_LOG2+1 bits, never exceeds 2**DEPTH_LOG2.
// STRUCTURE
//  Package uart_pkg:
//   - entry field indices (DATA_LSB=0, PERR=9, BRK=10, OVF=11), ENTRY_W.
//   - parity-mode constants PARITY_SPACE/ODD/EVEN/MARK.
//   - FSM state encodings ST_IDLE/ST_PUSH/ST_WAIT.
//  Sub-module sync_fifo (params WIDTH, DEPTH_LOG2):
//   - ports push/pop/din/dout/count/empty/full/clear; reuse for TX path.
//  Top: FSM, sticky flags, silence edge detector, irq logic.
// TESTING
//  1 Reset: rst=0 for 2 cycles -> count=0, empty=1, irq=0, rxAck=0; hold after rst=1.
//  2 Single frame: rxData=9'h0A5, rxValid rises cycle N
//    -> rxAck=1 only in N+1; headEntry=12'h0A5, count=1 at N+1;
//    popReq -> empty=1.
//  3 Error flags:
//    rxValid+rxParityErr, rxData=9'h155 -> headEntry=12'h355;
//    rxBreak alone -> 12'h400; rxValid+rxOverflow, data 0x01 -> 12'h801.
//  4 Full, DEPTH_LOG2=2:
//    push 4 (0x10..0x13) -> count=4; 5th frame -> dropped=1, count=4, rxAck still pulses;
//    5th frame with popReq in PUSH cycle -> accepted, count=4, head=0x11.
//  5 irq: threshold=3, push 2 -> irq=0; 3rd -> irq=1; pop 1 -> irq=0;
//    rxSilence 0->1 with count=2 -> irq=1; pop both -> irq=0.
//  6 flush in same cycle as PUSH, count=2 -> count=0, dropped=0, rxAck=1;
//    mid-stream rst=0 -> all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// UART receive-path shared definitions: entry layout, parity modes,
// receive-sequencer state encodings and an entry-packing helper.
package uart_pkg;

    // FIFO entry layout: {ovf, brk, perr, data[8:0]}
    localparam int DATA_W   = 9;
    localparam int ENTRY_W  = 12;
    localparam int DATA_LSB = 0;
    localparam int PERR     = 9;
    localparam int BRK      = 10;
    localparam int OVF      = 11;

    // Parity modes shared with UartReceiver / transmitter configuration
    localparam logic [1:0] PARITY_SPACE = 2'd0;
    localparam logic [1:0] PARITY_ODD   = 2'd1;
    localparam logic [1:0] PARITY_EVEN  = 2'd2;
    localparam logic [1:0] PARITY_MARK  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PUSH = 2'b01,
        ST_WAIT = 2'b10
    } rxState_t;

    // Data and parity only mean something when a character was received;
    // a bare break frame carries zero data and no parity error.
    function automatic logic [ENTRY_W-1:0] makeEntry(
        input logic [DATA_W-1:0] data,
        input logic              valid,
        input logic              perr,
        input logic              brk,
        input logic              ovf
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[DATA_LSB +: DATA_W] = valid ? data : '0;
        e[PERR] = valid & perr;
        e[BRK]  = brk;
        e[OVF]  = ovf;
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// Bundle between UartReceiver/host and the receive FIFO controller.
// slave: controller view; master: receiver + host view.
interface uart_rx_fifo_ctrl_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    import uart_pkg::*;

    // UartReceiver side
    logic [DATA_W-1:0]     rxData;
    logic                  rxValid;
    logic                  rxParityErr;
    logic                  rxOverflow;
    logic                  rxBreak;
    logic                  rxSilence;
    logic                  rxAck;

    // Host / register side
    logic                  popReq;
    logic [ENTRY_W-1:0]    headEntry;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   threshold;
    logic                  flush;
    logic                  dropped;
    logic                  irq;

    modport slave (
        input  rxData, rxValid, rxParityErr, rxOverflow,
        input  rxBreak, rxSilence,
        output rxAck,
        input  popReq, threshold, flush,
        output headEntry, empty, count, dropped, irq
    );

    modport master (
        output rxData, rxValid, rxParityErr, rxOverflow,
        output rxBreak, rxSilence,
        input  rxAck,
        output popReq, threshold, flush,
        input  headEntry, empty, count, dropped, irq
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, 2**DEPTH_LOG2 entries.
// Ports: clk, rst (sync, active-low), clear, push/din, pop/dout, count, empty, full.
module sync_fifo #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic                  doPush;
    logic                  doPop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // goes through when the same-cycle pop frees the head slot.
    assign doPop  = pop && !empty && !clear;
    assign doPush = push && (!full || doPop) && !clear;

    // Empty output reads as zero rather than a stale slot.
    assign dout = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (doPush && !doPop) begin
                count <= count + CNT_ONE;
            end else if (doPop && !doPush) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Acknowledges UartReceiver frames, queues {ovf,brk,perr,data} for the host.
// Ports: clk, rst (sync, active-low), bus (slave: receiver + host signals).
module uart_rx_fifo_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int ENTRY_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_fifo_ctrl_if.slave bus
);
    import uart_pkg::*;

    localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;

    rxState_t            state;
    logic                ackQ;
    logic                droppedQ;
    logic                timeoutIrq;
    logic                silPrev;

    logic                frameIn;
    logic                pushReq;
    logic                fifoPush;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [DEPTH_LOG2:0] fifoCount;
    logic [ENTRY_W-1:0]  entry;
    logic                willDrop;
    logic                goingEmpty;
    logic                silRise;

    assign frameIn = bus.rxValid | bus.rxBreak;

    // The entry is written on the same edge that enters PUSH, so the new
    // entry and the rxAck pulse become visible together.
    assign pushReq  = (state == ST_IDLE) && frameIn;
    assign fifoPush = pushReq && !bus.flush;

    assign entry = makeEntry(bus.rxData, bus.rxValid, bus.rxParityErr,
                             bus.rxBreak, bus.rxOverflow);

    // Full implies non-empty, so popReq always frees a slot here.
    assign willDrop   = fifoPush && fifoFull && !bus.popReq;
    assign goingEmpty = (fifoCount == CNT_ONE) && bus.popReq && !fifoPush;
    assign silRise    = bus.rxSilence && !silPrev;

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .push  (fifoPush),
        .din   (entry),
        .pop   (bus.popReq),
        .dout  (bus.headEntry),
        .count (fifoCount),
        .empty (fifoEmpty),
        .full  (fifoFull)
    );

    // PUSH always falls through to WAIT, so rxAck lasts exactly one cycle.
    // WAIT holds off re-entry until the receiver has dropped its flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            ackQ  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (frameIn) begin
                        state <= ST_PUSH;
                        ackQ  <= 1'b1;
                    end
                end
                ST_PUSH: begin
                    state <= ST_WAIT;
                    ackQ  <= 1'b0;
                end
                ST_WAIT: begin
                    ackQ <= 1'b0;
                    if (!frameIn) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ackQ  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            silPrev    <= 1'b0;
            droppedQ   <= 1'b0;
            timeoutIrq <= 1'b0;
        end else begin
            silPrev <= bus.rxSilence;

            if (bus.flush) begin
                droppedQ <= 1'b0;
            end else if (willDrop) begin
                droppedQ <= 1'b1;
            end

            if (bus.flush || fifoCount == '0 || goingEmpty) begin
                timeoutIrq <= 1'b0;
            end else if (silRise) begin
                timeoutIrq <= 1'b1;
            end
        end
    end

    assign bus.rxAck   = ackQ;
    assign bus.count   = fifoCount;
    assign bus.empty   = fifoEmpty;
    assign bus.dropped = droppedQ;
    assign bus.irq     = ((bus.threshold != '0) &&
                          (fifoCount >= bus.threshold)) || timeoutIrq;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl (DEPTH_LOG2=2).
// Table vectors for entry formatting plus hand sequences for FIFO/irq corners.
module tb_uart_rx_fifo_ctrl;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic clk = 1'b0;
    logic rst;

    uart_rx_fifo_ctrl_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_rx_fifo_ctrl #(
        .DEPTH_LOG2 (DL2),
        .ENTRY_W    (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  data;
        logic        v;
        logic        p;
        logic        o;
        logic        b;
        logic [11:0] exp;
    } vec_t;

    int          nVec  = 0;
    int          nFail = 0;
    logic [11:0] sb[$];
    int          mCount;
    logic        mDropped;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, " count"}, 32'(bus.count), 0);
        check({tag, " empty"}, 32'(bus.empty), 1);
        check({tag, " irq"}, 32'(bus.irq), 0);
        check({tag, " rxAck"}, 32'(bus.rxAck), 0);
        check({tag, " dropped"}, 32'(bus.dropped), 0);
        check({tag, " head"}, 32'(bus.headEntry), 0);
    endtask

    // One receiver frame: flags high for one cycle, then dropped.
    task automatic sendFrame(input logic [8:0] d, input logic v, p, o, b,
                             input logic [11:0] exp,
                             input bit withPop, withFlush);
        bus.rxData      = d;
        bus.rxValid     = v;
        bus.rxParityErr = p;
        bus.rxOverflow  = o;
        bus.rxBreak     = b;
        bus.popReq      = withPop;
        bus.flush       = withFlush;
        if (withFlush) begin
            sb.delete();
            mCount   = 0;
            mDropped = 0;
        end else begin
            if (withPop && mCount > 0) begin
                check("popHead", 32'(bus.headEntry), 32'(sb.pop_front()));
                mCount--;
            end
            if (mCount < DEPTH) begin
                sb.push_back(exp);
                mCount++;
            end else begin
                mDropped = 1;
            end
        end
        tick();
        bus.rxValid     = 0;
        bus.rxBreak     = 0;
        bus.rxParityErr = 0;
        bus.rxOverflow  = 0;
        bus.popReq      = 0;
        bus.flush       = 0;
        check("frame rxAck", 32'(bus.rxAck), 1);
        check("frame count", 32'(bus.count), 32'(mCount));
        check("frame dropped", 32'(bus.dropped), 32'(mDropped));
        tick();
        check("frame ackEnd", 32'(bus.rxAck), 0);
        tick();
    endtask

    task automatic popOne();
        check("pop notEmpty", 32'(bus.empty), 0);
        check("pop head", 32'(bus.headEntry), 32'(sb.pop_front()));
        bus.popReq = 1;
        tick();
        bus.popReq = 0;
        mCount--;
        check("pop count", 32'(bus.count), 32'(mCount));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{9'h0A5, 1, 0, 0, 0, 12'h0A5};
        vecs[1] = '{9'h155, 1, 1, 0, 0, 12'h355};
        vecs[2] = '{9'h1FF, 0, 1, 0, 1, 12'h400};
        vecs[3] = '{9'h001, 1, 0, 1, 0, 12'h801};
        vecs[4] = '{9'h1FF, 1, 1, 1, 1, 12'hFFF};
        vecs[5] = '{9'h000, 1, 0, 0, 0, 12'h000};

        rst             = 0;
        bus.rxData      = '0;
        bus.rxValid     = 0;
        bus.rxParityErr = 0;
        bus.rxOverflow  = 0;
        bus.rxBreak     = 0;
        bus.rxSilence   = 0;
        bus.popReq      = 0;
        bus.threshold   = '0;
        bus.flush       = 0;
        mCount          = 0;
        mDropped        = 0;

        // Reset and hold
        tick();
        tick();
        checkReset("reset");
        rst = 1;
        tick();
        checkReset("hold");

        // Entry formatting table, single frame each
        for (int i = 0; i < 6; i++) begin
            sendFrame(vecs[i].data, vecs[i].v, vecs[i].p, vecs[i].o,
                      vecs[i].b, vecs[i].exp, 0, 0);
            check($sformatf("vec%0d head", i), 32'(bus.headEntry),
                  32'(vecs[i].exp));
            popOne();
            check($sformatf("vec%0d empty", i), 32'(bus.empty), 1);
            check($sformatf("vec%0d headZero", i), 32'(bus.headEntry), 0);
        end

        // rxValid held several cycles: one entry, one ack pulse
        bus.rxData  = 9'h077;
        bus.rxValid = 1;
        tick();
        check("hold ack1", 32'(bus.rxAck), 1);
        check("hold count1", 32'(bus.count), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold ackLow", 32'(bus.rxAck), 0);
            check("hold countStay", 32'(bus.count), 1);
        end
        bus.rxValid = 0;
        tick();
        tick();
        sb.push_back(12'h077);
        mCount = 1;
        popOne();

        // Fill to full, drop, then push with simultaneous pop
        for (int i = 0; i < DEPTH; i++) begin
            sendFrame(9'(16 + i), 1, 0, 0, 0, 12'(16 + i), 0, 0);
        end
        check("full count", 32'(bus.count), 4);
        check("full irqOff", 32'(bus.irq), 0);
        sendFrame(9'h014, 1, 0, 0, 0, 12'h014, 0, 0);
        check("drop sticky", 32'(bus.dropped), 1);
        sendFrame(9'h015, 1, 0, 0, 0, 12'h015, 1, 0);
        check("fullPop count", 32'(bus.count), 4);
        check("fullPop head", 32'(bus.headEntry), 12'h011);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        sb.delete();
        mCount   = 0;
        mDropped = 0;
        check("flush count", 32'(bus.count), 0);
        check("flush dropped", 32'(bus.dropped), 0);
        check("flush empty", 32'(bus.empty), 1);

        // Level and timeout irq
        bus.threshold = 3;
        sendFrame(9'h031, 1, 0, 0, 0, 12'h031, 0, 0);
        sendFrame(9'h032, 1, 0, 0, 0, 12'h032, 0, 0);
        check("irq below", 32'(bus.irq), 0);
        sendFrame(9'h033, 1, 0, 0, 0, 12'h033, 0, 0);
        check("irq level", 32'(bus.irq), 1);
        popOne();
        check("irq afterPop", 32'(bus.irq), 0);
        bus.rxSilence = 1;
        tick();
        check("irq timeout", 32'(bus.irq), 1);
        popOne();
        check("irq timeoutHeld", 32'(bus.irq), 1);
        popOne();
        check("irq timeoutClr", 32'(bus.irq), 0);
        bus.rxSilence = 0;
        tick();
        bus.rxSilence = 1;
        tick();
        tick();
        check("irq silenceEmpty", 32'(bus.irq), 0);
        bus.rxSilence = 0;
        tick();

        // Flush in the push cycle
        bus.threshold = 0;
        sendFrame(9'h021, 1, 0, 0, 0, 12'h021, 0, 0);
        sendFrame(9'h022, 1, 0, 0, 0, 12'h022, 0, 0);
        check("preFlush count", 32'(bus.count), 2);
        sendFrame(9'h023, 1, 0, 0, 0, 12'h023, 0, 1);
        check("flushPush empty", 32'(bus.empty), 1);

        // Mid-stream reset with rxValid still asserted
        bus.threshold = 2;
        for (int i = 0; i < DEPTH + 1; i++) begin
            sendFrame(9'(64 + i), 1, 0, 0, 0, 12'(64 + i), 0, 0);
        end
        check("preRst dropped", 32'(bus.dropped), 1);
        check("preRst irq", 32'(bus.irq), 1);
        popOne();
        bus.rxData  = 9'h03C;
        bus.rxValid = 1;
        tick();
        check("preRst ack", 32'(bus.rxAck), 1);
        rst = 0;
        tick();
        tick();
        checkReset("midRst");
        sb.delete();
        mCount   = 0;
        mDropped = 0;
        rst = 1;
        tick();
        check("postRst ack", 32'(bus.rxAck), 1);
        check("postRst count", 32'(bus.count), 1);
        check("postRst head", 32'(bus.headEntry), 12'h03C);
        bus.rxValid = 0;
        tick();
        check("postRst ackLow", 32'(bus.rxAck), 0);
        tick();
        check("postRst countStay", 32'(bus.count), 1);
        sb.push_back(12'h03C);
        mCount = 1;
        popOne();
        check("final empty", 32'(bus.empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
